// File: rtl/xif_acc_dispatcher.sv
// xif_acc_dispatcher
//
// Fans a single CV-X-IF coprocessor port out to NUM_ACC accelerators.
// Issue transactions are routed by major opcode, and every accepted instruction
// ID is remembered so that later register, commit and kill transactions reach
// the same unit. Results from all units are merged round-robin into one
// registered result channel back to the core.
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   issue_* / register_* / commit_*   core-side request channels
//   result_*                      registered result channel to the core
//   acc_issue_* / acc_register_*  per-unit valid/ready; instr, id and operands
//                                 are broadcast unmodified on shared buses
//   acc_commit_*                  per-unit commit valid, broadcast id/kill
//   acc_result_*                  per-unit result channels, packed NUM_ACC x field
//
// ACC_OPCODES lists accelerator 0 as the leftmost (most significant) entry of
// the concatenation, so the default {7'h5B, 7'h2B} gives unit 0 = 0x5B and
// unit 1 = 0x2B.
module xif_acc_dispatcher #(
    parameter int                   NUM_ACC         = 2,
    parameter logic [NUM_ACC*7-1:0] ACC_OPCODES     = {7'h5B, 7'h2B},
    parameter int                   ID_WIDTH        = 4,
    parameter int                   NUM_RS          = 2,
    parameter int                   XLEN            = 64,
    parameter int                   MAX_OUTSTANDING = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        issue_valid_i,
    output logic                        issue_ready_o,
    input  logic [31:0]                 issue_instr_i,
    input  logic [ID_WIDTH-1:0]         issue_id_i,
    output logic                        issue_accept_o,
    output logic                        issue_writeback_o,
    input  logic                        register_valid_i,
    output logic                        register_ready_o,
    input  logic [ID_WIDTH-1:0]         register_id_i,
    input  logic [NUM_RS*XLEN-1:0]      rs_i,
    input  logic [NUM_RS-1:0]           rs_valid_i,
    input  logic                        commit_valid_i,
    input  logic [ID_WIDTH-1:0]         commit_id_i,
    input  logic                        commit_kill_i,
    output logic                        result_valid_o,
    input  logic                        result_ready_i,
    output logic [ID_WIDTH-1:0]         result_id_o,
    output logic [XLEN-1:0]             result_data_o,
    output logic [4:0]                  result_rd_o,
    output logic                        result_we_o,
    output logic [NUM_ACC-1:0]          acc_issue_valid_o,
    input  logic [NUM_ACC-1:0]          acc_issue_ready_i,
    input  logic [NUM_ACC-1:0]          acc_accept_i,
    input  logic [NUM_ACC-1:0]          acc_writeback_i,
    output logic [31:0]                 acc_issue_instr_o,
    output logic [ID_WIDTH-1:0]         acc_issue_id_o,
    output logic [NUM_ACC-1:0]          acc_register_valid_o,
    input  logic [NUM_ACC-1:0]          acc_register_ready_i,
    output logic [ID_WIDTH-1:0]         acc_register_id_o,
    output logic [NUM_RS*XLEN-1:0]      acc_rs_o,
    output logic [NUM_RS-1:0]           acc_rs_valid_o,
    output logic [NUM_ACC-1:0]          acc_commit_valid_o,
    output logic [ID_WIDTH-1:0]         acc_commit_id_o,
    output logic                        acc_commit_kill_o,
    input  logic [NUM_ACC-1:0]          acc_result_valid_i,
    output logic [NUM_ACC-1:0]          acc_result_ready_o,
    input  logic [NUM_ACC*ID_WIDTH-1:0] acc_result_id_i,
    input  logic [NUM_ACC*XLEN-1:0]     acc_result_data_i,
    input  logic [NUM_ACC*5-1:0]        acc_result_rd_i,
    input  logic [NUM_ACC-1:0]          acc_result_we_i
);

    localparam int NUM_IDS = 1 << ID_WIDTH;
    localparam int CNT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam int ACC_W   = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    logic [NUM_IDS-1:0]              busy_q, busy_d, wb_q, wb_d;
    logic [NUM_IDS-1:0][ACC_W-1:0]   acc_q, acc_d;
    logic [NUM_ACC-1:0][CNT_W-1:0]   count_q, count_d;
    logic [ACC_W-1:0]                rr_q, rr_d;
    logic                            result_valid_q, result_valid_d;
    logic [ID_WIDTH-1:0]             result_id_q, result_id_d;
    logic [XLEN-1:0]                 result_data_q, result_data_d;
    logic [4:0]                      result_rd_q, result_rd_d;
    logic                            result_we_q, result_we_d;

    logic                hit, issue_stall, issue_fire;
    logic [ACC_W-1:0]    hit_idx, reg_acc, commit_acc, grant_idx, cand;
    logic                commit_free, req_found, grant, grant_free;
    logic [ID_WIDTH-1:0] grant_id;

    // Unpacked views of the per-unit opcode and result fields
    logic [6:0]          acc_opcode [NUM_ACC];
    logic [ID_WIDTH-1:0] res_id     [NUM_ACC];
    logic [XLEN-1:0]     res_data   [NUM_ACC];
    logic [4:0]          res_rd     [NUM_ACC];

    for (genvar g = 0; g < NUM_ACC; g++) begin : g_unit
        assign acc_opcode[g] = ACC_OPCODES[(NUM_ACC-1-g)*7 +: 7];
        assign res_id[g]     = acc_result_id_i[g*ID_WIDTH +: ID_WIDTH];
        assign res_data[g]   = acc_result_data_i[g*XLEN +: XLEN];
        assign res_rd[g]     = acc_result_rd_i[g*5 +: 5];
    end

    // Payloads are broadcast; only the valids are steered per unit
    assign acc_issue_instr_o = issue_instr_i;
    assign acc_issue_id_o    = issue_id_i;
    assign acc_register_id_o = register_id_i;
    assign acc_rs_o          = rs_i;
    assign acc_rs_valid_o    = rs_valid_i;
    assign acc_commit_id_o   = commit_id_i;
    assign acc_commit_kill_o = commit_kill_i;

    // Descending scan so the lowest matching unit index is the one left standing
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NUM_ACC - 1; i >= 0; i--) begin
            if (issue_instr_i[6:0] == acc_opcode[i]) begin
                hit     = 1'b1;
                hit_idx = ACC_W'(i);
            end
        end
    end

    // Unknown opcodes are answered immediately with accept=0 so the core can
    // raise an illegal-instruction; known opcodes stall on a reused ID or a full unit
    always_comb begin
        issue_stall       = busy_q[issue_id_i] || (count_q[hit_idx] == CNT_MAX);
        acc_issue_valid_o = '0;
        issue_ready_o     = 1'b1;
        issue_accept_o    = 1'b0;
        issue_writeback_o = 1'b0;
        if (hit) begin
            if (issue_stall) begin
                issue_ready_o = 1'b0;
            end else begin
                acc_issue_valid_o[hit_idx] = issue_valid_i;
                issue_ready_o              = acc_issue_ready_i[hit_idx];
                issue_accept_o             = acc_accept_i[hit_idx];
                issue_writeback_o          = acc_writeback_i[hit_idx];
            end
        end
        issue_fire = hit && !issue_stall && issue_valid_i && issue_ready_o && issue_accept_o;
    end

    // Register and commit follow the unit recorded for the ID; unknown IDs
    // are swallowed so a stray transaction cannot block the core
    always_comb begin
        reg_acc              = acc_q[register_id_i];
        acc_register_valid_o = '0;
        register_ready_o     = 1'b1;
        if (busy_q[register_id_i]) begin
            acc_register_valid_o[reg_acc] = register_valid_i;
            register_ready_o              = acc_register_ready_i[reg_acc];
        end
        commit_acc         = acc_q[commit_id_i];
        acc_commit_valid_o = '0;
        acc_commit_valid_o[commit_acc] = commit_valid_i && busy_q[commit_id_i];
        commit_free = commit_valid_i && busy_q[commit_id_i] && (commit_kill_i || !wb_q[commit_id_i]);
    end

    // Round-robin: candidates are scanned from rr_q+NUM_ACC down to rr_q+1 so
    // the unit right after the last grant has the highest priority
    always_comb begin
        req_found = 1'b0;
        grant_idx = rr_q;
        cand      = '0;
        for (int k = NUM_ACC; k >= 1; k--) begin
            cand = ACC_W'((int'(rr_q) + k) % NUM_ACC);
            if (acc_result_valid_i[cand]) begin
                req_found = 1'b1;
                grant_idx = cand;
            end
        end
        grant              = req_found && (!result_valid_q || result_ready_i);
        acc_result_ready_o = '0;
        acc_result_ready_o[grant_idx] = grant;
        grant_id   = res_id[grant_idx];
        // A kill and a result for the same ID in one cycle must only free it once
        grant_free = grant && busy_q[grant_id] && !(commit_free && (commit_id_i == grant_id));
    end

    // Table, counter and output-register next state; frees are applied before
    // the allocation so an allocate of the same ID wins
    always_comb begin
        busy_d = busy_q;
        acc_d  = acc_q;
        wb_d   = wb_q;
        if (commit_free) busy_d[commit_id_i] = 1'b0;
        if (grant_free)  busy_d[grant_id]    = 1'b0;
        if (issue_fire) begin
            busy_d[issue_id_i] = 1'b1;
            acc_d[issue_id_i]  = hit_idx;
            wb_d[issue_id_i]   = issue_writeback_o;
        end
        for (int i = 0; i < NUM_ACC; i++) begin
            count_d[i] = count_q[i]
                       + CNT_W'(issue_fire  && (hit_idx    == ACC_W'(i)))
                       - CNT_W'(commit_free && (commit_acc == ACC_W'(i)))
                       - CNT_W'(grant_free  && (grant_idx  == ACC_W'(i)));
        end
        rr_d           = grant ? grant_idx : rr_q;
        result_valid_d = grant ? 1'b1 : (result_ready_i ? 1'b0 : result_valid_q);
        result_id_d    = result_id_q;
        result_data_d  = result_data_q;
        result_rd_d    = result_rd_q;
        result_we_d    = result_we_q;
        if (grant) begin
            result_id_d   = grant_id;
            result_data_d = res_data[grant_idx];
            result_rd_d   = res_rd[grant_idx];
            result_we_d   = acc_result_we_i[grant_idx];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q         <= '0;
            acc_q          <= '0;
            wb_q           <= '0;
            count_q        <= '0;
            rr_q           <= '0;
            result_valid_q <= 1'b0;
            result_id_q    <= '0;
            result_data_q  <= '0;
            result_rd_q    <= '0;
            result_we_q    <= 1'b0;
        end else begin
            busy_q         <= busy_d;
            acc_q          <= acc_d;
            wb_q           <= wb_d;
            count_q        <= count_d;
            rr_q           <= rr_d;
            result_valid_q <= result_valid_d;
            result_id_q    <= result_id_d;
            result_data_q  <= result_data_d;
            result_rd_q    <= result_rd_d;
            result_we_q    <= result_we_d;
        end
    end

    assign result_valid_o = result_valid_q;
    assign result_id_o    = result_id_q;
    assign result_data_o  = result_data_q;
    assign result_rd_o    = result_rd_q;
    assign result_we_o    = result_we_q;

endmodule
